// File: rtl/alu_seq_param.sv
// Clocked ALU: single-cycle add/sub/logic/shift, iterative mul/div.
// Build option ALU_MUL_EARLY_TERM_EN ends a multiply once the multiplier is exhausted.
module alu_seq_param #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

    state_t state_q, state_d;

    logic               accept, is_iter, div0, go_iter;
    logic               last, run_end;
    logic [SHW-1:0]     amt, cnt;
    logic [WIDTH:0]     sum, diff, shl_ext, shr_ext, sar_ext;
    logic [WIDTH-1:0]   sc_out;
    logic               sc_c, sc_v;
    logic [2*WIDTH-1:0] acc, mcand, acc_nx, prod;
    logic [WIDTH-1:0]   mplier, mplier_nx, a_mag, b_mag;
    logic [WIDTH-1:0]   quo, quo_nx, rem, rem_nx, divisor;
    logic [WIDTH:0]     rem_sh, rem_sub;
    logic               neg;
    logic [1:0]         iop;
    logic [WIDTH-1:0]   fin_out;
    logic               fin_c, fin_v;

    assign accept  = start && !busy;
    assign is_iter = (op[3:2] == 2'b11);
    assign div0    = op[1] && (in1 == '0);
    assign go_iter = accept && is_iter && !div0;
    assign amt     = in1[SHW-1:0];

    // Extra bit on each shift captures the bit pushed out.
    always_comb begin
        sum     = {1'b0, in0} + {1'b0, in1};
        diff    = {1'b0, in0} - {1'b0, in1};
        shl_ext = {1'b0, in0} << amt;
        shr_ext = {in0, 1'b0} >> amt;
        sar_ext = $signed({in0, 1'b0}) >>> amt;
        sc_out  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        unique case (op)
            4'b0000: begin
                sc_out = sum[WIDTH-1:0];
                sc_v   = (in0[WIDTH-1] == in1[WIDTH-1]) &&
                         (sum[WIDTH-1] != in0[WIDTH-1]);
            end
            4'b0001: begin
                sc_out = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
            end
            4'b0010: begin
                sc_out = diff[WIDTH-1:0];
                sc_v   = (in0[WIDTH-1] != in1[WIDTH-1]) &&
                         (diff[WIDTH-1] != in0[WIDTH-1]);
            end
            4'b0011: begin
                sc_out = diff[WIDTH-1:0];
                sc_c   = diff[WIDTH];
            end
            4'b0100: sc_out = in0 & in1;
            4'b0101: sc_out = in0 | in1;
            4'b0110: sc_out = in0 ^ in1;
            4'b0111: sc_out = ~(in0 | in1);
            4'b1000, 4'b1011: begin
                sc_out = shl_ext[WIDTH-1:0];
                sc_c   = shl_ext[WIDTH];
            end
            4'b1001: begin
                sc_out = shr_ext[WIDTH:1];
                sc_c   = shr_ext[0];
            end
            4'b1010: begin
                sc_out = sar_ext[WIDTH:1];
                sc_c   = sar_ext[0];
            end
            default: begin
                sc_out = op[0] ? in0 : '1;
                sc_v   = 1'b1;
            end
        endcase
    end

    assign a_mag = (!op[0] && in0[WIDTH-1]) ? -in0 : in0;
    assign b_mag = (!op[0] && in1[WIDTH-1]) ? -in1 : in1;

    assign acc_nx    = mplier[0] ? acc + mcand : acc;
    assign mplier_nx = mplier >> 1;
    assign rem_sh    = {rem, quo[WIDTH-1]};
    assign rem_sub   = rem_sh - {1'b0, divisor};
    assign quo_nx    = {quo[WIDTH-2:0], ~rem_sub[WIDTH]};
    assign rem_nx    = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
    assign last      = &cnt;

`ifdef ALU_MUL_EARLY_TERM_EN
    assign run_end = last || (!iop[1] && (mplier_nx == '0));
`else
    assign run_end = last;
`endif

    assign prod = neg ? -acc : acc;

    always_comb begin
        fin_out = prod[WIDTH-1:0];
        fin_c   = 1'b0;
        fin_v   = 1'b0;
        unique case (iop)
            2'b00: fin_v = !((&prod[2*WIDTH-1:WIDTH-1]) ||
                             (~|prod[2*WIDTH-1:WIDTH-1]));
            2'b01: fin_c = |prod[2*WIDTH-1:WIDTH];
            2'b10: fin_out = quo;
            2'b11: fin_out = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go_iter) state_d = RUN;
            RUN:     if (run_end) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            out      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            neg      <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            divisor  <= '0;
            cnt      <= '0;
            iop      <= 2'b00;
        end else begin
            done <= 1'b0;
            if (go_iter) begin
                iop     <= op[1:0];
                cnt     <= '0;
                acc     <= '0;
                mcand   <= {{WIDTH{1'b0}}, a_mag};
                mplier  <= b_mag;
                neg     <= !op[0] && (in0[WIDTH-1] ^ in1[WIDTH-1]);
                quo     <= in0;
                rem     <= '0;
                divisor <= in1;
            end else if (accept) begin
                out      <= sc_out;
                carryout <= sc_c;
                overflow <= sc_v;
                zero     <= (sc_out == '0);
                done     <= 1'b1;
            end
            if (state_q == RUN) begin
                cnt <= cnt + SHW'(1);
                if (iop[1]) begin
                    quo <= quo_nx;
                    rem <= rem_nx;
                end else begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier_nx;
                end
            end
            if (state_q == FIN) begin
                out      <= fin_out;
                carryout <= fin_c;
                overflow <= fin_v;
                zero     <= (fin_out == '0);
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
Parametrised, clocked successor to the combinational 32-bit ALU. It keeps the same 4-bit op encoding for add/sub/logic/shift and adds iterative multiply and divide. All results are registered and returned through a start/busy/done handshake. It sits between the operand register file and the writeback stage of the teaching CPU datapath.

Parameters:
WIDTH, 32, operand/result width in bits; must be a power of two and at least 8.
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while busy=0
op  input  4  operation code, sampled with start
in0  input  WIDTH  operand A, sampled with start
in1  input  WIDTH  operand B, sampled with start
busy  output  1  iterative operation in progress
done  output  1  one-cycle pulse; out and flags are valid from this cycle on
out  output  WIDTH  registered result
carryout  output  1  registered carry/borrow/shifted-out bit
overflow  output  1  registered signed overflow / exception flag
zero  output  1  registered flag: out == 0

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: busy=0, done=0, out=0, carryout=0, overflow=0, zero=0; FSM returns to IDLE.
- Reset mid-operation: aborts the operation; no done pulse is produced for it.
- FSM states: IDLE, RUN, FIN.
- Start while busy=1 is ignored. Start in the same cycle as done is accepted (back-to-back operation).
- Single-cycle ops (op 0000-1011):
  - On the start edge E0, out and flags are loaded and done=1 for the following cycle.
  - busy stays 0. Latency is 1.
- Op encodings:
  - 0000 add: overflow = signed overflow; carryout=0.
  - 0001 addu: carryout = bit WIDTH of the sum; overflow=0.
  - 0010 sub: overflow = signed overflow; carryout=0.
  - 0011 subu: carryout = borrow (in0 < in1 unsigned); overflow=0.
  - 0100 and, 0101 or, 0110 xor, 0111 nor: carryout=0, overflow=0.
  - 1000 shl, 1011 sal: amount = in1[SHW-1:0]; carryout = in0[WIDTH-amt] when amt≠0, else 0.
  - 1001 shr, 1010 sar: carryout = in0[amt-1] when amt≠0, else 0. sar replicates in0[WIDTH-1].
  - All shifts: overflow=0.
  - 1100 mul: signed; out = low WIDTH bits of the product. overflow=1 if the full 2*WIDTH signed product does not sign-fit in WIDTH bits; carryout=0.
  - 1101 mulu: unsigned; out = low WIDTH bits. carryout=1 if the high half of the product ≠ 0; overflow=0.
  - 1110 divu: out = unsigned quotient.
  - 1111 remu: out = unsigned remainder.
  - divu/remu: carryout=0.
- Iterative ops (1100-1111):
  - E0 latches operands and enters RUN; busy=1 from the cycle after E0.
  - RUN performs one shift-add (mul) or one restoring-subtract (div) step per edge, on edges E1..E(WIDTH).
  - FIN at E(WIDTH+1) writes out and flags and pulses done; busy=0 in the done cycle.
  - Latency is WIDTH+1 edges after E0.
  - mul internally uses operand magnitudes with sign correction, and keeps a 2*WIDTH accumulator.
- Divide by zero (in1 == 0, divu/remu):
  - Detected at E0; the op is treated as single-cycle.
  - Results: quotient = all ones, remainder = in0, overflow=1.
- zero: always recomputed from the final out of every op.
- Between done pulses, out and the flags hold their last values.
- done is never asserted for two consecutive cycles unless a new start was accepted in between.

Optional Feature:
ALU_MUL_EARLY_TERM_EN:
- Defined: in RUN for mul/mulu, once the remaining unshifted multiplier bits are all zero, the FSM goes to FIN on the next edge. Minimum mul latency is 2; the result and flags are identical to the full-length run. div is unaffected.
- Undefined: mul always takes exactly WIDTH+1 cycles.

Test Plan:
1. Reset and first add (WIDTH=32): assert rst_n=0 mid-mul at cycle 5, release -> all outputs 0, no done pulse. Then start add 7FFFFFFF+00000001 -> next cycle done=1, out=80000000, overflow=1, carryout=0, zero=0.
2. Unsigned add and subtract: start addu FFFFFFFF+00000001 -> out=0, carryout=1, zero=1. Then, in the done cycle, start subu 3-5 -> out=FFFFFFFE, carryout=1.
3. Shifts: shl 80000001 by 1 -> out=00000002, carryout=1. sar 80000000 by 4 -> out=F8000000, carryout=0. shr 0000000F by 0 -> out=0000000F, carryout=0.
4. Multiply: mul FFFFFFFE * 00000003 -> done exactly 33 cycles after start, out=FFFFFFFA, overflow=0, busy=1 during cycles 1..32. mulu 00010000*00010000 -> out=0, carryout=1, zero=1. Start pulsed while busy -> ignored.
5. Divide: divu 00000064/00000007 -> out=0000000E after 33 cycles. remu with the same operands -> out=00000002. divu by 0 with in0=12345678 -> next-cycle done, out=FFFFFFFF, overflow=1.
6. With ALU_MUL_EARLY_TERM_EN defined: mulu 00001234*00000003 -> done in ≤3 cycles, out=0000369C. Check against a reference model on 10k random ops under both macro settings.
